fifo_flagged: RTL
=================

# fifo_flagged

Parametrised synchronous register FIFO with level reporting, programmable almost-full/almost-empty thresholds, a synchronous flush and optional sticky overflow/underflow flags. It generalises the basic UART FIFO to any depth ≥ 2, including non-power-of-two depths. It sits between the UART RX/TX engines and the command parser in the single system clock domain. It does not cross clock domains.

## Interface
- pFifoDepth, 16: number of words; any integer ≥ 2.
- pFifoDataWidth, 8: word width in bits; ≥ 1.
- pAlmostFullLevel, 12: oAlmostFull asserts when count ≥ this value; range 1..pFifoDepth.
- pAlmostEmptyLevel, 2: oAlmostEmpty asserts when count ≤ this value; range 0..pFifoDepth-1.
- Localparam CW = $clog2(pFifoDepth+1): width of the count port.

Ports:
- iClk  in  1  system clock; all logic on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iFlush  in  1  synchronous flush; empties the FIFO and has priority over read/write.
- iWriteEn  in  1  write request.
- iWriteData  in  pFifoDataWidth  write word.
- oFifoFull  out  1  count == pFifoDepth.
- iReadEn  in  1  read request; consumes the word currently on oReadData.
- oReadData  out  pFifoDataWidth  head word, show-ahead; forced to 0 while empty.
- oFifoEmpty  out  1  count == 0.
- oAlmostFull  out  1  count ≥ pAlmostFullLevel.
- oAlmostEmpty  out  1  count ≤ pAlmostEmptyLevel.
- oFifoCount  out  CW  number of stored words.
- iClearFlags  in  1  clears the sticky error flags.
- oOverflow  out  1  sticky: a write was rejected.
- oUnderflow  out  1  sticky: a read was rejected.

## Operation
- A write is accepted when iWriteEn=1 and either the FIFO is not full, or it is full and iReadEn=1 in the same cycle.
- A read is accepted when iReadEn=1 and the FIFO is not empty. A simultaneous write does not rescue a read from empty.
- An accepted write stores iWriteData at the write pointer and advances that pointer.
- An accepted read advances the read pointer.
- Pointers wrap from pFifoDepth-1 to 0 by explicit compare, so no power-of-two assumption is made.
- Count update:
  - +1 for a write alone.
  - −1 for a read alone.
  - Unchanged when both are accepted.
  - Count never exceeds pFifoDepth and never goes below 0.
- Full and both requests: both are accepted. The old head is read out while the new word fills the freed slot.
- Empty and both requests: the write is accepted and the read is rejected.
- iFlush=1: pointers and count go to 0. Read and write requests in that cycle are ignored and raise no error flags. Memory contents are left as they are.
- Error flags (with the macro defined):
  - oOverflow sets on iWriteEn while full without a same-cycle accepted read.
  - oUnderflow sets on iReadEn while empty.
  - Both hold until iClearFlags or iRst.
  - If iClearFlags and a new error occur in the same cycle, set wins.
- All status outputs are decoded from the registered count only. They are glitch-free relative to iClk and have no combinational path from the inputs.

## Timing
- Reset values: count 0, pointers 0, oFifoEmpty=1, oFifoFull=0, oAlmostEmpty=1, oAlmostFull=0 (for pAlmostFullLevel ≥ 1), oReadData=0, oOverflow=0, oUnderflow=0. Memory is not reset.
- Write-to-read latency is 1 cycle: a word written at edge N appears on oReadData, with oFifoEmpty=0, after edge N.
- Read: oReadData is valid in the same cycle as iReadEn. The next word is presented after the edge.
- Flags and oFifoCount reflect the count after the most recent edge.
- Reset mid-operation: the FIFO returns to its reset state on the next edge. iRst has priority over iFlush, and iFlush has priority over read/write.
- Sustained throughput is one write plus one read per cycle.

## Configuration
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: oOverflow/oUnderflow behave as specified under Operation, and iClearFlags is functional.
- Undefined: oOverflow/oUnderflow are tied to 0, iClearFlags is ignored, and no flag registers are synthesised. Acceptance rules are unchanged.

## Structure
- Shared package fifo_pkg holds the count-width helper (clog2 of depth+1) and the default depth/width constants used by the UART instances.
- Sub-module fifo_ptr: a wrapping pointer register with a modulo-depth increment, instanced once for the read pointer and once for the write pointer.
- Memory, count and flag logic stay in fifo_flagged.

## Test plan
All scenarios use depth 5, width 8, almost-full level 4, almost-empty level 1, FIFO_ERR_FLAGS_EN defined unless stated.

- Write 0x11..0x55 -> count 1..5; oAlmostFull rises at count 4, oFifoFull at count 5; read back in order 0x11..0x55; then empty=1 and oReadData=0.
- Fill to 5, then 7 write/read cycles (wrap) -> count holds at 5, full stays 1, data order preserved across the pointer wrap, no overflow.
- Full and write alone -> write rejected, count 5, oOverflow=1. Empty and read+write with 0xA5 -> count 1, oUnderflow=1, head 0xA5. iClearFlags -> both flags 0 next cycle.
- Count 3, assert iFlush with iWriteEn and iReadEn -> count 0, empty=1, no flags set; next write of 0x7E reads back 0x7E.
- Assert iRst with count 4 and oOverflow set -> all outputs at reset values after the edge. Rebuild without FIFO_ERR_FLAGS_EN, overflow and underflow the FIFO -> oOverflow and oUnderflow stay 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and the count-width helper
package fifo_pkg;

   localparam int cUartFifoDepth = 16;
   localparam int cUartFifoDataWidth = 8;

   function automatic int countWidth(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// fifo_flagged_if: FIFO write/read/status bundle with producer-side and FIFO-side views
interface fifo_flagged_if
   import fifo_pkg::*;
#(
   parameter int pFifoDataWidth = cUartFifoDataWidth,
   parameter int CW = countWidth(cUartFifoDepth)
);

   logic iFlush;
   logic iWriteEn;
   logic [pFifoDataWidth-1:0] iWriteData;
   logic iReadEn;
   logic iClearFlags;
   logic oFifoFull;
   logic [pFifoDataWidth-1:0] oReadData;
   logic oFifoEmpty;
   logic oAlmostFull;
   logic oAlmostEmpty;
   logic [CW-1:0] oFifoCount;
   logic oOverflow;
   logic oUnderflow;

   modport master (
      output iFlush, iWriteEn, iWriteData, iReadEn, iClearFlags,
      input oFifoFull, oReadData, oFifoEmpty, oAlmostFull, oAlmostEmpty, oFifoCount, oOverflow, oUnderflow
   );

   modport slave (
      input iFlush, iWriteEn, iWriteData, iReadEn, iClearFlags,
      output oFifoFull, oReadData, oFifoEmpty, oAlmostFull, oAlmostEmpty, oFifoCount, oOverflow, oUnderflow
   );

endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer register, increments modulo pDepth (any depth >= 2)
module fifo_ptr #(
   parameter int pDepth = 16,
   localparam int PW = $clog2(pDepth)
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iClear,
   input  logic iAdvance,
   output logic [PW-1:0] oPtr
);

   // explicit compare for the wrap so non-power-of-two depths work
   always_ff @(posedge iClk)
      if (iRst || iClear) oPtr <= '0;
      else if (iAdvance) oPtr <= (oPtr == PW'(pDepth - 1)) ? '0 : oPtr + PW'(1);

endmodule

// File: rtl/fifo_flagged.sv
// fifo_flagged: register FIFO with level flags, flush and optional sticky errors (FIFO_ERR_FLAGS_EN)
module fifo_flagged
   import fifo_pkg::*;
#(
   parameter int pFifoDepth = cUartFifoDepth,
   parameter int pFifoDataWidth = cUartFifoDataWidth,
   parameter int pAlmostFullLevel = 12,
   parameter int pAlmostEmptyLevel = 2
) (
   input logic iClk,
   input logic iRst,
   fifo_flagged_if.slave bus
);

   localparam int CW = countWidth(pFifoDepth);
   localparam int PW = $clog2(pFifoDepth);

   logic [pFifoDataWidth-1:0] mem [pFifoDepth];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [CW-1:0] count;
   logic full, empty, wrAcc, rdAcc;

   assign full = count == CW'(pFifoDepth);
   assign empty = count == '0;
   assign rdAcc = bus.iReadEn && !empty && !bus.iFlush;
   assign wrAcc = bus.iWriteEn && (!full || bus.iReadEn) && !bus.iFlush;

   fifo_ptr #(.pDepth(pFifoDepth)) uRdPtr (.iClk(iClk), .iRst(iRst), .iClear(bus.iFlush), .iAdvance(rdAcc), .oPtr(rdPtr));
   fifo_ptr #(.pDepth(pFifoDepth)) uWrPtr (.iClk(iClk), .iRst(iRst), .iClear(bus.iFlush), .iAdvance(wrAcc), .oPtr(wrPtr));

   // storage is never reset; only pointers and count define what is valid
   always_ff @(posedge iClk)
      if (wrAcc) mem[wrPtr] <= bus.iWriteData;

   // occupancy: reset and flush dominate, simultaneous read+write leaves it unchanged
   always_ff @(posedge iClk)
      if (iRst || bus.iFlush) count <= '0;
      else if (wrAcc && !rdAcc) count <= count + CW'(1);
      else if (rdAcc && !wrAcc) count <= count - CW'(1);

   assign bus.oReadData = empty ? '0 : mem[rdPtr];
   assign bus.oFifoFull = full;
   assign bus.oFifoEmpty = empty;
   assign bus.oAlmostFull = count >= CW'(pAlmostFullLevel);
   assign bus.oAlmostEmpty = count <= CW'(pAlmostEmptyLevel);
   assign bus.oFifoCount = count;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow, underflow, ovfSet, unfSet;

   assign ovfSet = bus.iWriteEn && full && !bus.iReadEn && !bus.iFlush;
   assign unfSet = bus.iReadEn && empty && !bus.iFlush;

   // sticky error flags; a new error in the clearing cycle wins
   always_ff @(posedge iClk)
      if (iRst) begin
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow <= ovfSet || (overflow && !bus.iClearFlags);
         underflow <= unfSet || (underflow && !bus.iClearFlags);
      end

   assign bus.oOverflow = overflow;
   assign bus.oUnderflow = underflow;
`else
   logic unusedClearFlags;

   assign unusedClearFlags = bus.iClearFlags;
   assign bus.oOverflow = 1'b0;
   assign bus.oUnderflow = 1'b0;
`endif

endmodule
